mod_updown_cnt: RTL
===================

# mod_updown_cnt

`mod_updown_cnt` is a parametrised modulo-N up/down counter. It is the successor to the team's fixed 4-bit binary up-counter and adds:
- configurable width and modulus;
- direction control;
- synchronous load;
- count enable;
- wrap or saturate mode;
- a registered terminal-count pulse and a sticky overflow flag.

It drives timing and sequencing logic in the demo designs (BCD digits, clock dividers, event tallies).

## Interface
Parameters:
- `WIDTH`, 4, counter width in bits.
- `MOD`, 16, count modulus; the legal range is 0..`MOD`-1; constraint 2 <= `MOD` <= 2^`WIDTH`.
- `RESET_VAL`, 0, counter value after reset; constraint `RESET_VAL` < `MOD`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  `WIDTH`  value captured on load.
- `sat_mode`  in  1  0 = wrap at boundaries, 1 = saturate at boundaries.
- `clr_ovf`  in  1  clears the sticky overflow flag.
- `counter`  out  `WIDTH`  current count, registered.
- `tc`  out  1  terminal-count pulse, registered.
- `ovf`  out  1  sticky boundary-event flag, registered.

## Operation
**Reset.** `reset`=0 forces `counter`=`RESET_VAL`, `tc`=0, `ovf`=0 immediately, independent of `clk`. This holds even mid-count or mid-load.

**Priority per rising edge.** Reset, then `load`, then `en`, then hold.

**Load** (`load`=1):
- `counter` <= `load_val`.
- If `load_val` >= `MOD`, `counter` <= `MOD`-1 (clamp).
- Load is never a boundary event: `tc` <= 0, and `ovf` is unchanged except by `clr_ovf`.
- Load wins over `en` in the same cycle.

**Count** (`load`=0, `en`=1):
- Up, `counter` < `MOD`-1: `counter`+1.
- Up, `counter` = `MOD`-1: boundary event. Wrap mode gives 0; saturate mode holds at `MOD`-1.
- Down, `counter` > 0: `counter`-1.
- Down, `counter` = 0: boundary event. Wrap mode gives `MOD`-1; saturate mode holds at 0.

**Idle** (`load`=0, `en`=0): `counter` holds and `tc` <= 0.

**Boundary event.**
- `tc` <= 1 for exactly the next cycle. Repeated saturating attempts give one pulse per attempted step.
- `ovf` <= 1.

**Overflow clear.**
- `clr_ovf`=1 without a boundary event: `ovf` <= 0.
- Simultaneous boundary event and `clr_ovf`: set wins, `ovf`=1.

**Other rules.**
- `up` and `sat_mode` are sampled only on counting edges and may change any cycle.
- All arithmetic is unsigned `WIDTH`-bit; a `counter` value >= `MOD` is unreachable.
- When `MOD` = 2^`WIDTH`, wrap is natural binary rollover.

## Timing
- Load-to-output latency: 1 cycle.
- Count step latency: 1 cycle.
- `tc` is asserted in the same cycle the post-boundary `counter` value is visible.
- `clr_ovf` takes effect 1 cycle later.
- No combinational path from any input to any output.
- Reset assertion is asynchronous. Reset release takes effect on the first rising `clk` edge after `reset` returns to 1. The first count occurs on that edge if `en`=1.

## Structure
- Shared package `cnt_pkg`:
  - `cnt_mode_e` enum {`CNT_WRAP`, `CNT_SAT`}, mapped from `sat_mode`;
  - `cnt_dir_e` enum {`CNT_DOWN`, `CNT_UP`};
  - helper function `cnt_next(cur, up, sat, mod)` returning the next value and the boundary flag.
- Sub-module `dff_bank`: parametrised `WIDTH`-bit register with asynchronous active-low reset and reset-value parameter. It is the generalisation of the team's single-bit positive-edge DFF, and is instantiated for `counter`, `tc` and `ovf`.
- Next-state logic lives in the top module.
- Elaboration-time assertions check the parameter constraints.

## Test plan
All scenarios use `WIDTH`=4, `MOD`=10, `RESET_VAL`=0.
1. Reset, then `en`=1, `up`=1, wrap mode, for 12 cycles -> `counter` goes 1..9, 0, 1, 2. `tc`=1 only in the cycle `counter`=0. `ovf`=1 from then on.
2. `load`=1, `load_val`=3, then `en`=1, `up`=0, wrap mode -> `counter` goes 3, 2, 1, 0, 9. `tc` pulses with 9. A simultaneous `load` and `en` loads and does not count.
3. Saturate mode, `load_val`=8, `up`=1, `en`=1 for 4 cycles -> `counter` goes 8, 9, 9, 9. `tc` pulses on each of the two held-at-9 cycles. `counter` never shows 0.
4. `load_val`=14 -> `counter`=9 (clamped). `tc`=0, and `ovf` is unchanged.
5. Hold `clr_ovf`=1 during a wrap edge -> `ovf` stays 1. `clr_ovf`=1 on the next non-boundary edge -> `ovf`=0.
6. Assert `reset`=0 asynchronously mid-count with `counter`=6 -> `counter`, `tc` and `ovf` all read 0 before the next clock edge. Release `reset` with `en`=1 -> the first edge gives `counter`=1.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared types and next-value helper for the modulo-N up/down counter family.
// Values are carried at CNT_MAXW bits so one helper serves every counter width.
package cnt_pkg;

   localparam int CNT_MAXW = 31;

   typedef logic [CNT_MAXW-1:0] cnt_val_t;
   typedef logic [CNT_MAXW:0]   cnt_mod_t;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   typedef enum logic {
      CNT_DOWN = 1'b0,
      CNT_UP   = 1'b1
   } cnt_dir_e;

   typedef struct packed {
      logic     bnd;
      cnt_val_t nxt;
   } cnt_res_t;

   // A boundary event is any step attempted from the top or bottom of the range,
   // whether it wraps or is held by saturation.
   function automatic cnt_res_t cnt_next(input cnt_val_t  cur,
                                         input cnt_dir_e  up,
                                         input cnt_mode_e sat,
                                         input cnt_mod_t  mod);
      cnt_res_t res;
      cnt_val_t last;
      last    = cnt_val_t'(mod - cnt_mod_t'(1));
      res.bnd = 1'b0;
      res.nxt = cur;
      if (up == CNT_UP) begin
         if (cur >= last) begin
            res.bnd = 1'b1;
            res.nxt = (sat == CNT_SAT) ? last : '0;
         end else begin
            res.nxt = cur + cnt_val_t'(1);
         end
      end else begin
         if (cur == '0) begin
            res.bnd = 1'b1;
            res.nxt = (sat == CNT_SAT) ? '0 : last;
         end else begin
            res.nxt = cur - cnt_val_t'(1);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mod_updown_cnt_dff_bank.sv
// Parametrised register bank with asynchronous active-low reset to RST_VAL.
// Latency 1 cycle; no backpressure, captures d_i on every rising edge.
module dff_bank #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_o <= RST_VAL;
      end else begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/mod_updown_cnt.sv
// Modulo-MOD up/down counter: load > enable > hold, wrap or saturate, tc pulse, sticky ovf.
// Latency 1 cycle from any input to outputs; no backpressure, all outputs registered.
module mod_updown_cnt
   import cnt_pkg::*;
#(
   parameter int          WIDTH     = 4,
   parameter int unsigned MOD       = 16,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat_mode,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] counter,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

   if (WIDTH < 1 || WIDTH > CNT_MAXW) begin : g_bad_width
      $error("mod_updown_cnt: WIDTH out of range");
   end
   if (MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_mod
      $error("mod_updown_cnt: MOD must satisfy 2 <= MOD <= 2**WIDTH");
   end
   if (RESET_VAL >= MOD) begin : g_bad_rst
      $error("mod_updown_cnt: RESET_VAL must be below MOD");
   end

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   cnt_res_t         step;
   logic             unused_step;

   assign step        = cnt_next(cnt_val_t'(cnt_q), cnt_dir_e'(up),
                                 cnt_mode_e'(sat_mode), cnt_mod_t'(MOD));
   assign unused_step = ^step.nxt;

   // The boundary set is applied after the clear so a coincident clr_ovf loses.
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = clr_ovf ? 1'b0 : ovf_q;
      if (load) begin
         cnt_d = (load_val > LAST) ? LAST : load_val;
      end else if (en) begin
         cnt_d = step.nxt[WIDTH-1:0];
         tc_d  = step.bnd;
         if (step.bnd) begin
            ovf_d = 1'b1;
         end
      end
   end

   dff_bank #(.WIDTH(WIDTH), .RST_VAL(RST_CNT)) u_cnt_reg (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (cnt_d),
      .q_o    (cnt_q)
   );

   dff_bank #(.WIDTH(1), .RST_VAL(1'b0)) u_tc_reg (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (tc_d),
      .q_o    (tc_q)
   );

   dff_bank #(.WIDTH(1), .RST_VAL(1'b0)) u_ovf_reg (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (ovf_d),
      .q_o    (ovf_q)
   );

   assign counter = cnt_q;
   assign tc      = tc_q;
   assign ovf     = ovf_q;

endmodule
